regfile_scoreboard: RTL and testbench

Parametrised successor to the four-port register file, with DEPTH = 2**ADDR_W words of DATA_W bits.
- One write port and two registered read ports.
- Write-to-read bypass on each read port.
- Per-register busy scoreboard: a reserve port sets busy; a write clears it.
- Sits between the datapath ALU writeback and operand fetch, so the controller can stall on unresolved destinations.
- Also exports the live contents of register 0 for debug.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rf_read_port.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
// Instances override these through module parameters.
package regfile_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 4;
  localparam int RESET_VAL_DEF = 0;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: write bypass, data/valid/busy capture.
// Data and busy hold while the port is idle; valid drops.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              busy_bit,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              r_busy
);

  logic [DATA_W-1:0] read_word;

  // A write landing this edge must be visible to a same-cycle read.
  always_comb begin
    read_word = mem_word;
    if (w_en && (w_addr == r_addr)) read_word = w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= r_en;
      if (r_en) begin
        r_data <= read_word;
        r_busy <= busy_bit;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two bypassed registered read ports
// and a per-register busy scoreboard (reserve sets, write clears).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          W_en,
  input  logic [ADDR_W-1:0]             W_addr,
  input  logic [DATA_W-1:0]             W_data,
  input  logic                          Rsv_en,
  input  logic [ADDR_W-1:0]             Rsv_addr,
  input  logic                          R_en0,
  input  logic                          R_en1,
  input  logic [ADDR_W-1:0]             R_addr0,
  input  logic [ADDR_W-1:0]             R_addr1,
  output logic [DATA_W-1:0]             R_data0,
  output logic [DATA_W-1:0]             R_data1,
  output logic                          R_valid0,
  output logic                          R_valid1,
  output logic                          R_busy0,
  output logic                          R_busy1,
  output logic [depth_of(ADDR_W)-1:0]   Busy,
  output logic [DATA_W-1:0]             RQ0
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_next;

  // Reserve is applied after the write-clear so it wins on a collision.
  always_comb begin
    busy_next = busy_q;
    if (W_en)   busy_next[W_addr]   = 1'b0;
    if (Rsv_en) busy_next[Rsv_addr] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      busy_q <= '0;
    end else begin
      if (W_en) mem[W_addr] <= W_data;
      busy_q <= busy_next;
    end
  end

  assign Busy = busy_q;
  assign RQ0  = mem[0];

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port0 (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .r_en     (R_en0),
    .r_addr   (R_addr0),
    .mem_word (mem[R_addr0]),
    .busy_bit (busy_next[R_addr0]),
    .w_en     (W_en),
    .w_addr   (W_addr),
    .w_data   (W_data),
    .r_data   (R_data0),
    .r_valid  (R_valid0),
    .r_busy   (R_busy0)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .r_en     (R_en1),
    .r_addr   (R_addr1),
    .mem_word (mem[R_addr1]),
    .busy_bit (busy_next[R_addr1]),
    .w_en     (W_en),
    .w_addr   (W_addr),
    .w_data   (W_data),
    .r_data   (R_data1),
    .r_valid  (R_valid1),
    .r_busy   (R_busy1)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic
// checked every cycle against an array-based model of the register file.
module tb_regfile_scoreboard;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          W_en, Rsv_en, R_en0, R_en1;
  logic [AW-1:0] W_addr, Rsv_addr, R_addr0, R_addr1;
  logic [DW-1:0] W_data;
  logic [DW-1:0] R_data0, R_data1, RQ0;
  logic          R_valid0, R_valid1, R_busy0, R_busy1;
  logic [DEPTH-1:0] Busy;

  always #5 Clk = ~Clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .RESET_VAL(16'h0000)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .W_en(W_en), .W_addr(W_addr), .W_data(W_data),
    .Rsv_en(Rsv_en), .Rsv_addr(Rsv_addr),
    .R_en0(R_en0), .R_en1(R_en1), .R_addr0(R_addr0), .R_addr1(R_addr1),
    .R_data0(R_data0), .R_data1(R_data1),
    .R_valid0(R_valid0), .R_valid1(R_valid1),
    .R_busy0(R_busy0), .R_busy1(R_busy1),
    .Busy(Busy), .RQ0(RQ0)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0]    mMem [DEPTH];
  logic [DEPTH-1:0] mBusy;
  logic [DW-1:0]    mRdata [2];
  logic             mValid [2];
  logic             mRbusy [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
    mBusy = '0;
    for (int p = 0; p < 2; p++) begin
      mRdata[p] = '0;
      mValid[p] = 1'b0;
      mRbusy[p] = 1'b0;
    end
  endtask

  // One clock edge of register-file behaviour, from the current inputs.
  task automatic modelStep();
    logic [DEPTH-1:0] nb;
    logic             en [2];
    int               ra [2];
    nb = mBusy;
    if (W_en)   nb[W_addr]   = 1'b0;
    if (Rsv_en) nb[Rsv_addr] = 1'b1;
    en[0] = R_en0; ra[0] = int'(R_addr0);
    en[1] = R_en1; ra[1] = int'(R_addr1);
    for (int p = 0; p < 2; p++) begin
      mValid[p] = en[p];
      if (en[p]) begin
        mRdata[p] = (W_en && int'(W_addr) == ra[p]) ? W_data : mMem[ra[p]];
        mRbusy[p] = nb[ra[p]];
      end
    end
    if (W_en) mMem[W_addr] = W_data;
    mBusy = nb;
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_rq0"},    RQ0,      mMem[0]);
    checkOutput({tag, "_busy"},   Busy,     mBusy);
    checkOutput({tag, "_rdata0"}, R_data0,  mRdata[0]);
    checkOutput({tag, "_rdata1"}, R_data1,  mRdata[1]);
    checkOutput({tag, "_valid0"}, R_valid0, mValid[0]);
    checkOutput({tag, "_valid1"}, R_valid1, mValid[1]);
    checkOutput({tag, "_rbusy0"}, R_busy0,  mRbusy[0]);
    checkOutput({tag, "_rbusy1"}, R_busy1,  mRbusy[1]);
  endtask

  // Called just after a falling edge: drive, clock once, check at next fall.
  task automatic applyStimulus(input string tag,
                               input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic rs, input int rsa,
                               input logic re0, input int ra0,
                               input logic re1, input int ra1);
    W_en = we;   W_addr = AW'(wa);   W_data = wd;
    Rsv_en = rs; Rsv_addr = AW'(rsa);
    R_en0 = re0; R_addr0 = AW'(ra0);
    R_en1 = re1; R_addr1 = AW'(ra1);
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    compareAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset mid-cycle with a write pending, checks the asynchronous
  // clear, holds across an edge, then releases on a falling edge.
  task automatic midOpReset(input string tag, input int wa, input logic [DW-1:0] wd);
    W_en = 1'b1; W_addr = AW'(wa); W_data = wd;
    Rsv_en = 1'b1; Rsv_addr = AW'(wa + 1);
    #2 Reset_n = 1'b0;
    modelReset();
    #1;
    compareAll({tag, "_async"});
    @(posedge Clk);
    @(negedge Clk);
    compareAll({tag, "_held"});
    Reset_n = 1'b1;
    W_en = 1'b0; Rsv_en = 1'b0; R_en0 = 1'b0; R_en1 = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b1;
    W_en = 0; Rsv_en = 0; R_en0 = 0; R_en1 = 0;
    W_addr = '0; Rsv_addr = '0; R_addr0 = '0; R_addr1 = '0; W_data = '0;

    // Reset asserted between edges must clear outputs immediately.
    #2 Reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("t1_rq0",    RQ0,      16'h0000);
    checkOutput("t1_busy",   Busy,     16'h0000);
    checkOutput("t1_valid0", R_valid0, 1'b0);
    checkOutput("t1_valid1", R_valid1, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;

    applyStimulus("t2_wr", 1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    applyStimulus("t2_rd", 0, 0, '0, 0, 0, 1, 5, 0, 0);
    checkOutput("t2_rdata0", R_data0,  16'hBEEF);
    checkOutput("t2_valid0", R_valid0, 1'b1);
    checkOutput("t2_rbusy0", R_busy0,  1'b0);

    applyStimulus("t3_byp", 1, 3, 16'h1234, 0, 0, 0, 0, 1, 3);
    checkOutput("t3_rdata1", R_data1, 16'h1234);
    idle("t3_hold");
    checkOutput("t3_hold_rdata1", R_data1,  16'h1234);
    checkOutput("t3_hold_valid1", R_valid1, 1'b0);

    applyStimulus("t4_rsv", 0, 0, '0, 1, 7, 0, 0, 0, 0);
    checkOutput("t4_busy7", Busy[7], 1'b1);
    applyStimulus("t4_rd", 0, 0, '0, 0, 0, 1, 7, 0, 0);
    checkOutput("t4_rbusy0", R_busy0, 1'b1);
    applyStimulus("t4_wr", 1, 7, 16'h00AA, 0, 0, 1, 7, 0, 0);
    checkOutput("t4_busy7_clr", Busy[7], 1'b0);
    checkOutput("t4_rdata0",    R_data0, 16'h00AA);
    checkOutput("t4_rbusy0_clr", R_busy0, 1'b0);

    applyStimulus("t5_col", 1, 9, 16'h5555, 1, 9, 0, 0, 0, 0);
    checkOutput("t5_busy9", Busy[9], 1'b1);
    applyStimulus("t5_rd", 0, 0, '0, 0, 0, 1, 9, 1, 9);
    checkOutput("t5_rdata0", R_data0, 16'h5555);
    checkOutput("t5_rdata1", R_data1, 16'h5555);
    checkOutput("t5_rbusy0", R_busy0, 1'b1);
    checkOutput("t5_rbusy1", R_busy1, 1'b1);

    applyStimulus("t6_wr0", 1, 0, 16'hCAFE, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_rq0", RQ0, 16'hCAFE);
    midOpReset("t6_rst", 0, 16'h1111);
    checkOutput("t6_rq0_after", RQ0,  16'h0000);
    checkOutput("t6_busy_after", Busy, 16'h0000);

    // Random traffic with one reset dropped into the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        midOpReset("rnd_rst", int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end else begin
        applyStimulus($sformatf("rnd%0d", i),
                      ($urandom_range(0, 99) < 50), int'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                      ($urandom_range(0, 99) < 30), int'($urandom_range(0, DEPTH - 1)),
                      ($urandom_range(0, 99) < 60), int'($urandom_range(0, DEPTH - 1)),
                      ($urandom_range(0, 99) < 60), int'($urandom_range(0, DEPTH - 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
